// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and limits for the memory-port arbiter.
// Command latch fields are sized for address/data widths up to 32 bits.
package mem_arb_pkg;

   localparam int MAX_NREQ   = 8;
   localparam int MAX_RD_LAT = 4;
   localparam int IDX_W      = $clog2(MAX_NREQ);
   localparam int CNT_W      = $clog2(MAX_RD_LAT);
   localparam int CMD_AW     = 32;
   localparam int CMD_DW     = 32;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT_RD
   } arb_state_t;

   typedef struct packed {
      logic              write;
      logic [CMD_AW-1:0] addr;
      logic [CMD_DW-1:0] wdata;
      logic [IDX_W-1:0]  owner;
   } cmd_t;

endpackage

// File: rtl/mem_arb_rr_pick.sv
// mem_arb_rr_pick: combinational round-robin selector.
// Search starts one past the last winner and wraps at NREQ.
module mem_arb_rr_pick
   import mem_arb_pkg::*;
#(
   parameter int NREQ = 2
) (
   input  logic [NREQ-1:0]  req,
   input  logic [IDX_W-1:0] last,
   output logic [NREQ-1:0]  gnt,
   output logic [IDX_W-1:0] idx,
   output logic             any
);

   int c;

   always_comb begin
      gnt = '0;
      idx = '0;
      any = 1'b0;
      c   = 0;
      for (int k = 1; k <= NREQ; k++) begin
         c = (int'(last) + k) % NREQ;
         if (!any && req[c]) begin
            any    = 1'b1;
            gnt[c] = 1'b1;
            idx    = IDX_W'(c);
         end
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin sequencer sharing one memory port.
// Define MEM_ARB_SVA_EN to compile in the embedded assertion block.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int NREQ   = 2,
   parameter int AW     = 32,
   parameter int DW     = 32,
   parameter int RD_LAT = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [NREQ-1:0]   req_valid,
   input  logic [NREQ-1:0]   req_write,
   input  logic [NREQ*AW-1:0] req_addr,
   input  logic [NREQ*DW-1:0] req_wdata,
   output logic [NREQ-1:0]   req_ready,
   output logic [NREQ-1:0]   rsp_valid,
   output logic [DW-1:0]     rsp_rdata,
   output logic              write,
   output logic              read,
   output logic [AW-1:0]     addr,
   output logic [DW-1:0]     wdata,
   input  logic [DW-1:0]     rdata,
   output logic              busy
);

   arb_state_t       state_q, state_d;
   cmd_t             cmd_q, cmd_d;
   logic [IDX_W-1:0] ptr_q, idx;
   logic [CNT_W-1:0] cnt_q;
   logic [NREQ-1:0]  gnt, rsp_valid_q;
   logic [DW-1:0]    rsp_rdata_q;
   logic             any, accept;

   mem_arb_rr_pick #(.NREQ(NREQ)) u_pick (
      .req  (req_valid),
      .last (ptr_q),
      .gnt  (gnt),
      .idx  (idx),
      .any  (any)
   );

   // No grant while reset is held, so nothing is latched and then dropped.
   assign accept    = (state_q == IDLE) && any && !reset;
   assign req_ready = accept ? gnt : '0;

   always_comb begin
      cmd_d = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (gnt[i]) begin
            cmd_d.write = req_write[i];
            cmd_d.addr  = CMD_AW'(req_addr[i*AW +: AW]);
            cmd_d.wdata = CMD_DW'(req_wdata[i*DW +: DW]);
         end
      end
      cmd_d.owner = idx;
   end

   always_ff @(posedge clk) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (accept) state_d = ISSUE;
         ISSUE:   state_d = cmd_q.write ? IDLE : WAIT_RD;
         WAIT_RD: if (cnt_q == '0) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      write     = (state_q == ISSUE) && cmd_q.write;
      read      = (state_q == ISSUE) && !cmd_q.write;
      busy      = (state_q != IDLE);
      addr      = cmd_q.addr[AW-1:0];
      wdata     = cmd_q.wdata[DW-1:0];
      rsp_valid = rsp_valid_q;
      rsp_rdata = rsp_rdata_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cmd_q       <= '0;
         ptr_q       <= IDX_W'(NREQ - 1);
         cnt_q       <= '0;
         rsp_valid_q <= '0;
         rsp_rdata_q <= '0;
      end else begin
         rsp_valid_q <= '0;
         if (accept) begin
            cmd_q <= cmd_d;
            ptr_q <= idx;
         end
         if (state_q == ISSUE && !cmd_q.write)
            cnt_q <= CNT_W'(RD_LAT - 1);
         if (state_q == WAIT_RD) begin
            if (cnt_q == '0) begin
               rsp_valid_q <= NREQ'(1) << cmd_q.owner;
               rsp_rdata_q <= rdata;
            end else begin
               cnt_q <= cnt_q - 1'b1;
            end
         end
      end
   end

`ifdef MEM_ARB_SVA_EN
   logic [3:0] wait_cnt [NREQ];

   always_ff @(posedge clk) begin
      for (int i = 0; i < NREQ; i++) begin
         if (reset || !req_valid[i] || req_ready[i])
            wait_cnt[i] <= '0;
         else if (req_ready != '0)
            wait_cnt[i] <= wait_cnt[i] + 4'd1;
      end
   end

   a_rdy_oh: assert property (@(posedge clk) $onehot0(req_ready));
   a_no_wr_rd: assert property (@(posedge clk) !(write && read));
   a_rsp_oh: assert property (@(posedge clk) disable iff (reset)
      (rsp_valid != '0) |-> $onehot(rsp_valid));
   a_rsp_lat: assert property (@(posedge clk) disable iff (reset)
      (rsp_valid != '0) |-> $past(read, RD_LAT + 1));

   for (genvar g = 0; g < NREQ; g++) begin : g_fair
      a_fair: assert property (@(posedge clk) disable iff (reset)
         wait_cnt[g] < 4'(NREQ));
   end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed vector table on a 2-requester instance plus
// randomized scoreboard sweeps on 4-requester instances at RD_LAT 1 and 4.
module tb_mem_arbiter;

   typedef struct {
      logic [1:0]  v, w;
      logic [31:0] a0, d0, a1, d1, rd;
      logic [1:0]  rdy;
      logic        wr, rs;
      logic [31:0] ad, wd;
      logic        bz;
      logic [1:0]  rsv;
      logic [31:0] rsd;
   } vec_t;

   typedef struct {
      logic [3:0]  own;
      logic [31:0] dat;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_pass = 0;
   int n_tot  = 0;

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      n_tot++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   logic        m_rst;
   logic [1:0]  m_v, m_w, m_rdy, m_rsv;
   logic [63:0] m_a, m_d;
   logic [31:0] m_rsd, m_ad, m_wd, m_rdat;
   logic        m_wr, m_rd, m_bz;

   mem_arbiter #(.NREQ(2), .AW(32), .DW(32), .RD_LAT(2)) u_dut (
      .clk       (clk),
      .reset     (m_rst),
      .req_valid (m_v),
      .req_write (m_w),
      .req_addr  (m_a),
      .req_wdata (m_d),
      .req_ready (m_rdy),
      .rsp_valid (m_rsv),
      .rsp_rdata (m_rsd),
      .write     (m_wr),
      .read      (m_rd),
      .addr      (m_ad),
      .wdata     (m_wd),
      .rdata     (m_rdat),
      .busy      (m_bz)
   );

   vec_t tbl [$];

   task automatic run(input int lo, input int hi);
      for (int i = lo; i <= hi; i++) begin
         @(posedge clk);
         #1;
         m_v    = tbl[i].v;
         m_w    = tbl[i].w;
         m_a    = {tbl[i].a1, tbl[i].a0};
         m_d    = {tbl[i].d1, tbl[i].d0};
         m_rdat = tbl[i].rd;
         @(negedge clk);
         chk($sformatf("r%0d_ready", i), m_rdy, tbl[i].rdy);
         chk($sformatf("r%0d_write", i), m_wr, tbl[i].wr);
         chk($sformatf("r%0d_read", i), m_rd, tbl[i].rs);
         chk($sformatf("r%0d_addr", i), m_ad, tbl[i].ad);
         chk($sformatf("r%0d_wdata", i), m_wd, tbl[i].wd);
         chk($sformatf("r%0d_busy", i), m_bz, tbl[i].bz);
         chk($sformatf("r%0d_rsp_valid", i), m_rsv, tbl[i].rsv);
         if (tbl[i].rsv != 0)
            chk($sformatf("r%0d_rsp_rdata", i), m_rsd, tbl[i].rsd);
      end
   endtask

   for (genvar k = 0; k < 2; k++) begin : g_sw
      localparam int RL = (k == 0) ? 1 : 4;
      logic         rst_s;
      logic [3:0]   v, w, rdy, rsv;
      logic [127:0] a, d;
      logic         wr, rs, bz;
      logic [31:0]  ad, wd, rdat, rsd;
      logic [31:0]  mem  [16];
      logic [31:0]  sr   [RL];
      logic [31:0]  refm [16];
      exp_t         sbq  [$];
      bit           done, ovl, bad_rdy;
      int           rd_cyc, ncyc;

      mem_arbiter #(.NREQ(4), .AW(32), .DW(32), .RD_LAT(RL)) u_sw (
         .clk       (clk),
         .reset     (rst_s),
         .req_valid (v),
         .req_write (w),
         .req_addr  (a),
         .req_wdata (d),
         .req_ready (rdy),
         .rsp_valid (rsv),
         .rsp_rdata (rsd),
         .write     (wr),
         .read      (rs),
         .addr      (ad),
         .wdata     (wd),
         .rdata     (rdat),
         .busy      (bz)
      );

      // Memory returns data RL cycles after the strobe; garbage otherwise.
      always @(posedge clk) begin
         if (rst_s) begin
            for (int j = 0; j < 16; j++) mem[j] <= '0;
         end else if (wr) begin
            mem[ad[3:0]] <= wd;
         end
         sr[0] <= rs ? mem[ad[3:0]] : 32'hDEAD_BEEF;
         for (int j = 1; j < RL; j++) sr[j] <= sr[j-1];
      end
      assign rdat = sr[RL-1];

      initial begin
         ovl    = 1'b0;
         rd_cyc = -100;
         ncyc   = 0;
         forever begin
            @(negedge clk);
            ncyc++;
            if (!rst_s) begin
               if (wr && rs) ovl = 1'b1;
               if (rs) rd_cyc = ncyc;
               if (rsv != 0) begin
                  if (sbq.size() == 0) begin
                     chk($sformatf("sw%0d_extra_rsp", k), rsv, 0);
                  end else begin
                     exp_t e;
                     e = sbq.pop_front();
                     chk($sformatf("sw%0d_rsp_owner", k), rsv, e.own);
                     chk($sformatf("sw%0d_rsp_data", k), rsd, e.dat);
                     chk($sformatf("sw%0d_rsp_lat", k), ncyc - rd_cyc, RL + 1);
                  end
               end
            end
         end
      end

      initial begin
         int   acc, cyc, wi;
         int   since [4];
         logic hit;
         done    = 1'b0;
         bad_rdy = 1'b0;
         rst_s   = 1'b1;
         v = '0; w = '0; a = '0; d = '0;
         acc = 0; cyc = 0;
         for (int i = 0; i < 16; i++) refm[i] = '0;
         for (int i = 0; i < 4; i++) since[i] = 0;
         repeat (3) @(posedge clk);
         #1 rst_s = 1'b0;
         for (int i = 0; i < 4; i++) begin
            w[i]          = 1'($urandom_range(0, 1));
            a[i*32 +: 32] = 32'($urandom_range(0, 15));
            d[i*32 +: 32] = $urandom;
         end
         v = 4'hF;
         while (acc < 1000 && cyc < 20000) begin
            @(negedge clk);
            cyc++;
            hit = 1'b0;
            wi  = 0;
            if (!$onehot0(rdy)) bad_rdy = 1'b1;
            for (int i = 0; i < 4; i++)
               if (rdy[i]) begin hit = 1'b1; wi = i; end
            if (hit) begin
               chk($sformatf("sw%0d_fair_req%0d", k, wi), since[wi] < 4, 1);
               for (int i = 0; i < 4; i++)
                  since[i] = (i == wi) ? 0 : since[i] + 1;
               if (w[wi]) refm[a[wi*32 +: 4]] = d[wi*32 +: 32];
               else sbq.push_back(exp_t'{4'(1 << wi), refm[a[wi*32 +: 4]]});
               acc++;
            end
            @(posedge clk);
            #1;
            if (hit) begin
               w[wi]          = 1'($urandom_range(0, 1));
               a[wi*32 +: 32] = 32'($urandom_range(0, 15));
               d[wi*32 +: 32] = $urandom;
            end
         end
         chk($sformatf("sw%0d_accepts", k), acc, 1000);
         v = '0;
         repeat (RL + 4) @(negedge clk);
         chk($sformatf("sw%0d_pending", k), sbq.size(), 0);
         chk($sformatf("sw%0d_wr_rd_overlap", k), ovl, 0);
         chk($sformatf("sw%0d_ready_onehot", k), bad_rdy, 0);
         done = 1'b1;
      end
   end

   initial begin
      logic [1:0] seen;
      localparam logic [31:0] E = 32'hEE;
      //               v  w  a0   d0   a1   d1   rd     rdy wr rs ad  wd  bz rsv rsd
      tbl.push_back('{1, 1, 'h10, 'hA5, 0, 0, E,       1, 0, 0, 0, 0, 0, 0, 0});
      tbl.push_back('{0, 1, 'h10, 'hA5, 0, 0, E,       0, 1, 0, 'h10, 'hA5, 1, 0, 0});
      tbl.push_back('{0, 1, 'h10, 'hA5, 0, 0, E,       0, 0, 0, 'h10, 'hA5, 0, 0, 0});
      tbl.push_back('{2, 0, 0, 0, 'h10, 'h77, E,       2, 0, 0, 'h10, 'hA5, 0, 0, 0});
      tbl.push_back('{0, 0, 0, 0, 'h10, 'h77, E,       0, 0, 1, 'h10, 'h77, 1, 0, 0});
      tbl.push_back('{0, 0, 0, 0, 'h10, 'h77, E,       0, 0, 0, 'h10, 'h77, 1, 0, 0});
      tbl.push_back('{0, 0, 0, 0, 'h10, 'h77, 'hA5,    0, 0, 0, 'h10, 'h77, 1, 0, 0});
      tbl.push_back('{0, 0, 0, 0, 'h10, 'h77, E,       0, 0, 0, 'h10, 'h77, 0, 2, 'hA5});
      tbl.push_back('{2, 0, 0, 0, 'h20, 'h77, E,       2, 0, 0, 'h10, 'h77, 0, 0, 0});
      tbl.push_back('{1, 1, 'h30, 'h5A, 'h20, 'h77, E, 0, 0, 1, 'h20, 'h77, 1, 0, 0});
      tbl.push_back('{1, 1, 'h30, 'h5A, 'h20, 'h77, E, 0, 0, 0, 'h20, 'h77, 1, 0, 0});
      tbl.push_back('{1, 1, 'h30, 'h5A, 'h20, 'h77, 'h3C, 0, 0, 0, 'h20, 'h77, 1, 0, 0});
      tbl.push_back('{1, 1, 'h30, 'h5A, 'h20, 'h77, E, 1, 0, 0, 'h20, 'h77, 0, 2, 'h3C});
      tbl.push_back('{0, 1, 'h30, 'h5A, 'h20, 'h77, E, 0, 1, 0, 'h30, 'h5A, 1, 0, 0});
      tbl.push_back('{0, 1, 'h30, 'h5A, 'h20, 'h77, E, 0, 0, 0, 'h30, 'h5A, 0, 0, 0});
      // contention after reset: 0,1,0,1 two cycles apart
      tbl.push_back('{3, 3, 'h40, 'h11, 'h50, 'h22, E, 1, 0, 0, 0, 0, 0, 0, 0});
      tbl.push_back('{3, 3, 'h40, 'h11, 'h50, 'h22, E, 0, 1, 0, 'h40, 'h11, 1, 0, 0});
      tbl.push_back('{3, 3, 'h40, 'h11, 'h50, 'h22, E, 2, 0, 0, 'h40, 'h11, 0, 0, 0});
      tbl.push_back('{3, 3, 'h40, 'h11, 'h50, 'h22, E, 0, 1, 0, 'h50, 'h22, 1, 0, 0});
      tbl.push_back('{3, 3, 'h40, 'h11, 'h50, 'h22, E, 1, 0, 0, 'h50, 'h22, 0, 0, 0});
      tbl.push_back('{3, 3, 'h40, 'h11, 'h50, 'h22, E, 0, 1, 0, 'h40, 'h11, 1, 0, 0});
      tbl.push_back('{3, 3, 'h40, 'h11, 'h50, 'h22, E, 2, 0, 0, 'h40, 'h11, 0, 0, 0});
      tbl.push_back('{3, 3, 'h40, 'h11, 'h50, 'h22, E, 0, 1, 0, 'h50, 'h22, 1, 0, 0});
      tbl.push_back('{0, 3, 'h40, 'h11, 'h50, 'h22, E, 0, 0, 0, 'h50, 'h22, 0, 0, 0});

      m_rst = 1'b1;
      m_v = '0; m_w = '0; m_a = '0; m_d = '0; m_rdat = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset_busy", m_bz, 0);
      chk("reset_strobes", {m_wr, m_rd}, 0);
      chk("reset_addr_wdata", {m_ad, m_wd}, 0);
      chk("reset_rsp", {m_rsv, m_rsd}, 0);
      m_rst = 1'b0;

      run(0, 14);

      // reset during WAIT_RD drops the read
      @(posedge clk);
      #1;
      m_v = 2'b10; m_w = 2'b00; m_a = {32'h60, 32'h0}; m_d = '0;
      m_rdat = 32'hA5;
      @(negedge clk);
      chk("rst_rd_ready", m_rdy, 2'b10);
      @(posedge clk);
      #1 m_v = '0;
      @(negedge clk);
      chk("rst_rd_strobe", m_rd, 1);
      @(posedge clk);
      #1 m_rst = 1'b1;
      @(negedge clk);
      chk("rst_rd_wait_busy", m_bz, 1);
      @(posedge clk);
      #1 m_rst = 1'b0;
      @(negedge clk);
      chk("rst_rd_ready0", m_rdy, 0);
      chk("rst_rd_strobes0", {m_wr, m_rd, m_bz}, 0);
      chk("rst_rd_addr_wdata0", {m_ad, m_wd}, 0);
      chk("rst_rd_rsp0", {m_rsv, m_rsd}, 0);
      seen = '0;
      repeat (4) begin
         @(negedge clk);
         seen = seen | m_rsv;
      end
      chk("rst_rd_no_rsp", seen, 0);

      run(15, 23);

      for (int i = 0; i < 50000; i++) begin
         if (g_sw[0].done && g_sw[1].done) break;
         @(posedge clk);
      end
      chk("sweep_finished", {g_sw[1].done, g_sw[0].done}, 2'b11);

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Round-robin arbiter and sequencer that shares one external memory port between NREQ requesters. It accepts one read or write command at a time and drives the memory strobes, address and write data. For reads, it waits a fixed read latency, captures the returned data and routes it back to the requester that issued the read. It sits directly in front of the memory that `memory_data_integrity_check` monitors, so its memory-side outputs connect to that monitor's write/read/addr/wdata/rdata inputs.

## Interface
Parameters:
- NREQ, 2: number of requesters, 2..8.
- AW, 32: address width.
- DW, 32: data width.
- RD_LAT, 2: memory read latency in cycles, 1..4.

Ports:
- clk  in  1  clock; all logic on posedge.
- reset  in  1  reset; synchronous, active-high.
- req_valid  in  NREQ  per-requester command valid.
- req_write  in  NREQ  per-requester 1=write, 0=read.
- req_addr  in  NREQ*AW  per-requester address, packed; requester i at [i*AW +: AW].
- req_wdata  in  NREQ*DW  per-requester write data, packed the same way.
- req_ready  out  NREQ  one-hot accept strobe (combinational).
- rsp_valid  out  NREQ  one-hot read-return strobe, registered.
- rsp_rdata  out  DW  read data, valid with rsp_valid.
- write  out  1  memory write strobe.
- read  out  1  memory read strobe.
- addr  out  AW  memory address.
- wdata  out  DW  memory write data.
- rdata  in  DW  memory read data.
- busy  out  1  high in any state other than IDLE.

## Operation
- FSM states: IDLE, ISSUE, WAIT_RD.
- IDLE, some req_valid high:
  - Round-robin picker selects winner w.
  - req_ready[w]=1 for that cycle only.
  - Command (write flag, addr, wdata, owner w) latched.
  - Next state: ISSUE.
- IDLE, no req_valid high: remain in IDLE; req_ready stays 0.
- ISSUE:
  - write or read (per latched flag) high for exactly one cycle.
  - addr and wdata driven from the latch.
  - Write: next state IDLE.
  - Read: next state WAIT_RD, latency counter loaded.
- WAIT_RD:
  - Counts RD_LAT cycles.
  - Samples rdata in the RD_LAT-th cycle after the read strobe cycle.
  - Next cycle: rsp_valid[owner]=1 with the data for one cycle; state goes to IDLE.
- Round-robin pointer:
  - Holds the index of the last winner.
  - Search starts at last+1, wrapping at NREQ.
  - Pointer updates only on an accept.
  - Reset value NREQ-1, so requester 0 wins first.
- Requester handshake rules:
  - Hold valid/write/addr/wdata stable until ready is seen.
  - req_valid must not depend on req_ready.
  - req_ready may depend on req_valid.
- write and read are never high together.
- Only one command is outstanding at a time; there is no pipelining of commands.
- addr and wdata hold their last driven value between commands.

## Timing
- Reset values:
  - state IDLE.
  - write, read, rsp_valid, busy: 0.
  - addr, wdata, rsp_rdata: 0.
  - Pointer NREQ-1.
- Accept at edge T:
  - Memory strobe high in cycle T+1.
  - busy high from T+1.
- Write throughput: 2 cycles per write, so back-to-back accepts are 2 cycles apart.
- Read with strobe in cycle c:
  - rdata sampled in cycle c+RD_LAT.
  - rsp_valid high in cycle c+RD_LAT+1.
  - Next accept possible in cycle c+RD_LAT+1, i.e. rsp_valid and the next req_ready may coincide.
- Simultaneous requests: only the round-robin winner gets ready; the others wait.
- A request that stays asserted is granted within NREQ accepts.
- Reset asserted mid-operation (any state):
  - Next cycle all outputs are at reset values.
  - An in-flight read is dropped and no rsp_valid is issued.
  - An in-progress strobe is cut.

## Configuration
- MEM_ARB_SVA_EN defined: an embedded assertion block is compiled in. It checks:
  - req_ready is one-hot0.
  - write and read are never high together.
  - rsp_valid only follows a read strobe by exactly RD_LAT+1 cycles.
  - Every rsp_valid pulse is one-hot.
  - Fairness: a continuously valid requester is accepted within NREQ accepts.
- MEM_ARB_SVA_EN undefined: no assertions are compiled. Functional RTL is identical in both cases.

## Structure
- Package mem_arb_pkg holds:
  - State enum typedef arb_state_t (IDLE, ISSUE, WAIT_RD).
  - Constants MAX_NREQ=8 and MAX_RD_LAT=4.
  - Latched-command struct cmd_t (write flag, addr, wdata, owner).
- Sub-module mem_arb_rr_pick:
  - Combinational round-robin selector.
  - Inputs: request vector, last pointer.
  - Outputs: one-hot grant, index, any flag.

## Test plan
- Reset mid-read: reset high in the WAIT_RD cycle. No rsp_valid; all outputs 0 next cycle; the next accept goes to requester 0.
- Single write: requester 0 writes addr=0x10, wdata=0xA5. req_ready[0] at T; write=1, addr=0x10, wdata=0xA5 at T+1; busy drops at T+2.
- Single read, RD_LAT=2: requester 1 reads addr=0x10 and the memory returns 0xA5. read at c; rsp_valid[1]=1 and rsp_rdata=0xA5 at c+3; rsp_valid[0]=0.
- Contention, NREQ=2: both requesters hold continuous writes. Accept order is 0,1,0,1, spaced 2 cycles apart.
- Parameter sweep: NREQ=4 with all requesters issuing mixed reads and writes for 1000 commands, run at RD_LAT=1 and again at RD_LAT=4.
  - Every read returns the last value written to that address.
  - No write/read overlap.
  - Each requester accepted within 4 accepts.
- Back-to-back read then write: rsp_valid for the read and req_ready for the write occur in the same cycle, with no idle gap.
